// File: rtl/arith_ser_pkg.sv
// arith_ser_pkg: shared types, constants and frame-length helper for the result serializer
package arith_ser_pkg;

    typedef enum logic {IDLE, SEND} state_t;

    localparam int HDR_BYTES = 1;
    localparam int SEQ_WIDTH = 4;

    function automatic int frame_len(input int data_width);
        return HDR_BYTES + data_width / 8;
    endfunction

endpackage

// File: rtl/result_fifo.sv
// result_fifo: synchronous first-word-fall-through FIFO holding {carry, result} entries
module result_fifo #(
    parameter int WIDTH      = 33,
    parameter int DEPTH      = 4,
    parameter int PTR_WIDTH  = 2
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 push,
    input  logic                 pop,
    input  logic [WIDTH-1:0]     wdata,
    output logic [WIDTH-1:0]     rdata,
    output logic                 full,
    output logic                 empty,
    output logic [PTR_WIDTH:0]   count
);

    logic [WIDTH-1:0]     r_mem [DEPTH];
    logic [PTR_WIDTH-1:0] r_wptr;
    logic [PTR_WIDTH-1:0] r_rptr;
    logic [PTR_WIDTH:0]   r_count;

    assign rdata = r_mem[r_rptr];
    assign full  = r_count == (PTR_WIDTH+1)'(DEPTH);
    assign empty = r_count == '0;
    assign count = r_count;

    // storage array; a write into the slot being popped is safe because the read is combinational
    always_ff @(posedge CLK) begin
        if (push)
            r_mem[r_wptr] <= wdata;
    end

    // pointers wrap naturally at DEPTH; occupancy is unchanged on simultaneous push and pop
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (push)
                r_wptr <= r_wptr + 1'b1;
            if (pop)
                r_rptr <= r_rptr + 1'b1;
            if (push && !pop)
                r_count <= r_count + 1'b1;
            else if (pop && !push)
                r_count <= r_count - 1'b1;
        end
    end

endmodule

// File: rtl/arith_result_serializer.sv
// arith_result_serializer: buffers ALU results and streams them as framed bytes over valid/ready
module arith_result_serializer
    import arith_ser_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int PTR_WIDTH  = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  Flag_IN,
    input  logic [DATA_WIDTH-1:0] Data_IN,
    input  logic                  Carry_IN,
    input  logic                  Byte_Ready,
    input  logic                  Clear_Overflow,
    output logic [7:0]            Byte_OUT,
    output logic                  Byte_Valid,
    output logic [PTR_WIDTH:0]    Fifo_Count,
    output logic                  Overflow
);

    localparam int FLEN = frame_len(DATA_WIDTH);
    localparam int IW   = $clog2(FLEN);

    state_t                r_state;
    logic                  r_flag_d;
    logic                  r_valid;
    logic                  r_ovf;
    logic [IW-1:0]         r_idx;
    logic [SEQ_WIDTH-1:0]  r_seq;
    logic [FLEN*8-1:0]     r_frame;
    logic [DATA_WIDTH:0]   w_rdata;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_accept;
    logic                  w_last;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_drop;

    assign w_accept = r_valid && Byte_Ready;
    assign w_last   = r_idx == IW'(FLEN - 1);
    assign w_pop    = !w_empty && (r_state == IDLE || (w_accept && w_last));
    assign w_push   = r_flag_d && (!w_full || w_pop);
    assign w_drop   = r_flag_d && w_full && !w_pop;

    assign Byte_OUT   = r_frame[7:0];
    assign Byte_Valid = r_valid;
    assign Overflow   = r_ovf;

    result_fifo #(
        .WIDTH     (DATA_WIDTH + 1),
        .DEPTH     (FIFO_DEPTH),
        .PTR_WIDTH (PTR_WIDTH)
    ) u_fifo (
        .CLK   (CLK),
        .RST   (RST),
        .push  (w_push),
        .pop   (w_pop),
        .wdata ({Carry_IN, Data_IN}),
        .rdata (w_rdata),
        .full  (w_full),
        .empty (w_empty),
        .count (Fifo_Count)
    );

    // the flag leads its registered result by one cycle, so delay it to line up with Data_IN
    always_ff @(posedge CLK) begin
        if (RST)
            r_flag_d <= 1'b0;
        else
            r_flag_d <= Flag_IN;
    end

    // sticky loss indicator; a new drop takes priority over a clear in the same cycle
    always_ff @(posedge CLK) begin
        if (RST)
            r_ovf <= 1'b0;
        else if (w_drop)
            r_ovf <= 1'b1;
        else if (Clear_Overflow)
            r_ovf <= 1'b0;
    end

    // serializer: load a whole frame on pop, shift one byte out per accepted handshake
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
            r_idx   <= '0;
            r_seq   <= '0;
            r_frame <= '0;
        end else if (w_pop) begin
            r_state <= SEND;
            r_valid <= 1'b1;
            r_idx   <= '0;
            r_seq   <= r_seq + 1'b1;
            r_frame <= {w_rdata[DATA_WIDTH-1:0], w_rdata[DATA_WIDTH], 3'b000, r_seq};
        end else if (w_accept) begin
            if (w_last) begin
                r_state <= IDLE;
                r_valid <= 1'b0;
                r_idx   <= '0;
            end else begin
                r_idx   <= r_idx + 1'b1;
                r_frame <= r_frame >> 8;
            end
        end
    end

endmodule

// File: tb/tb_arith_result_serializer.sv
// tb_arith_result_serializer: directed and randomized checks against a queue-based frame model
module tb_arith_result_serializer;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        Flag_IN = 1'b0;
    logic [31:0] Data_IN = '0;
    logic        Carry_IN = 1'b0;
    logic        Byte_Ready = 1'b0;
    logic        Clear_Overflow = 1'b0;
    logic [7:0]  Byte_OUT;
    logic        Byte_Valid;
    logic [2:0]  Fifo_Count;
    logic        Overflow;

    int checks = 0;
    int errors = 0;
    logic [7:0] got[$];

    arith_result_serializer #(.DATA_WIDTH(32), .FIFO_DEPTH(4), .PTR_WIDTH(2)) dut (
        .CLK            (CLK),
        .RST            (RST),
        .Flag_IN        (Flag_IN),
        .Data_IN        (Data_IN),
        .Carry_IN       (Carry_IN),
        .Byte_Ready     (Byte_Ready),
        .Clear_Overflow (Clear_Overflow),
        .Byte_OUT       (Byte_OUT),
        .Byte_Valid     (Byte_Valid),
        .Fifo_Count     (Fifo_Count),
        .Overflow       (Overflow)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: results wait in a queue of at most 4; the byte stream of the
    // frame being sent sits in mcur and is refilled the moment it runs out.
    logic [32:0] mq[$];
    logic [7:0]  mcur[$];
    int          mseq = 0;
    bit          mflag_d = 0;
    bit          movf = 0;

    always begin
        logic [32:0] e;
        bit dropped;
        @(posedge CLK);
        if (RST) begin
            mq.delete();
            mcur.delete();
            mseq = 0;
            mflag_d = 0;
            movf = 0;
        end else begin
            dropped = 0;
            if (mcur.size() > 0 && Byte_Ready)
                void'(mcur.pop_front());
            if (mcur.size() == 0 && mq.size() > 0) begin
                e = mq.pop_front();
                mcur.push_back({e[32], 3'b000, 4'(mseq)});
                for (int i = 0; i < 4; i++)
                    mcur.push_back(e[8*i +: 8]);
                mseq = (mseq + 1) % 16;
            end
            if (mflag_d) begin
                if (mq.size() < 4)
                    mq.push_back({Carry_IN, Data_IN});
                else
                    dropped = 1;
            end
            if (dropped)
                movf = 1;
            else if (Clear_Overflow)
                movf = 0;
            mflag_d = Flag_IN;
        end
        #1;
        chk("valid", Byte_Valid, mcur.size() > 0);
        chk("count", Fifo_Count, mq.size());
        chk("overflow", Overflow, movf);
        if (mcur.size() > 0)
            chk("byte", Byte_OUT, mcur[0]);
    end

    task automatic tick;
        @(negedge CLK);
    endtask

    task automatic do_reset;
        RST = 1'b1;
        Flag_IN = 1'b0;
        Clear_Overflow = 1'b0;
        tick;
        tick;
        chk("rst_valid", Byte_Valid, 0);
        chk("rst_byte", Byte_OUT, 0);
        chk("rst_count", Fifo_Count, 0);
        chk("rst_ovf", Overflow, 0);
        RST = 1'b0;
    endtask

    task automatic send(input logic [31:0] d, input logic c);
        Flag_IN = 1'b1;
        tick;
        Flag_IN = 1'b0;
        Data_IN = d;
        Carry_IN = c;
        tick;
    endtask

    task automatic collect(input int maxwait);
        int w = 0;
        got.delete();
        while (!Byte_Valid && w < maxwait) begin
            tick;
            w++;
        end
        if (!Byte_Valid)
            chk("collect_timeout", 0, 1);
        while (Byte_Valid && got.size() < 100) begin
            got.push_back(Byte_OUT);
            tick;
        end
    endtask

    initial begin
        logic [7:0] exp_single[5];
        exp_single = '{8'h80, 8'h78, 8'h56, 8'h34, 8'h12};

        // single result with latency check
        do_reset;
        Byte_Ready = 1'b1;
        send(32'h12345678, 1'b1);
        chk("lat_not_yet", Byte_Valid, 0);
        chk("lat_count", Fifo_Count, 1);
        for (int i = 0; i < 5; i++) begin
            tick;
            chk("single_valid", Byte_Valid, 1);
            chk("single_byte", Byte_OUT, exp_single[i]);
        end
        tick;
        chk("single_idle", Byte_Valid, 0);
        chk("single_count", Fifo_Count, 0);

        // backpressure holds the header
        do_reset;
        Byte_Ready = 1'b1;
        send(32'h12345678, 1'b1);
        tick;
        chk("bp_hdr", Byte_OUT, 8'h80);
        Byte_Ready = 1'b0;
        repeat (5) begin
            tick;
            chk("bp_hold_valid", Byte_Valid, 1);
            chk("bp_hold_byte", Byte_OUT, 8'h80);
        end
        Byte_Ready = 1'b1;
        for (int i = 1; i < 5; i++) begin
            tick;
            chk("bp_resume", Byte_OUT, exp_single[i]);
        end
        tick;
        chk("bp_idle", Byte_Valid, 0);

        // back-to-back frames with no bubble
        do_reset;
        Byte_Ready = 1'b1;
        Carry_IN = 1'b0;
        Flag_IN = 1'b1;
        tick;
        Data_IN = 32'h1;
        tick;
        Data_IN = 32'h2;
        tick;
        Flag_IN = 1'b0;
        Data_IN = 32'h3;
        collect(10);
        chk("b2b_len", got.size(), 15);
        if (got.size() == 15)
            for (int f = 0; f < 3; f++) begin
                chk("b2b_hdr", got[5*f], f);
                chk("b2b_data", got[5*f+1], f + 1);
                chk("b2b_hi", got[5*f+4], 0);
            end

        // overflow, clear, and drain of retained results
        do_reset;
        Byte_Ready = 1'b0;
        Carry_IN = 1'b0;
        Flag_IN = 1'b1;
        tick;
        for (int i = 0; i < 5; i++) begin
            Data_IN = 32'hA0 + i;
            tick;
        end
        Flag_IN = 1'b0;
        Data_IN = 32'hA5;
        tick;
        tick;
        chk("ovf_count", Fifo_Count, 4);
        chk("ovf_set", Overflow, 1);
        Clear_Overflow = 1'b1;
        tick;
        Clear_Overflow = 1'b0;
        chk("ovf_clear", Overflow, 0);
        Byte_Ready = 1'b1;
        collect(5);
        chk("ovf_len", got.size(), 25);
        if (got.size() == 25)
            for (int f = 0; f < 5; f++) begin
                chk("ovf_hdr", got[5*f], f);
                chk("ovf_data", got[5*f+1], 8'hA0 + f);
            end

        // sequence counter wraps after 16 frames
        do_reset;
        Byte_Ready = 1'b1;
        repeat (16) begin
            send($urandom, 1'b0);
            repeat (6) tick;
        end
        send(32'hCAFEF00D, 1'b1);
        tick;
        chk("wrap_valid", Byte_Valid, 1);
        chk("wrap_hdr", Byte_OUT, 8'h80);
        repeat (6) tick;

        // reset abandons a frame in flight and clears buffered results
        do_reset;
        Byte_Ready = 1'b1;
        send(32'h12345678, 1'b1);
        tick;
        Flag_IN = 1'b1;
        tick;
        Flag_IN = 1'b0;
        Data_IN = 32'h9;
        tick;
        chk("mid_pending", Fifo_Count, 1);
        RST = 1'b1;
        tick;
        chk("mid_valid", Byte_Valid, 0);
        chk("mid_count", Fifo_Count, 0);
        RST = 1'b0;
        send(32'h55, 1'b1);
        tick;
        chk("mid_hdr", Byte_OUT, 8'h80);
        repeat (6) tick;

        // randomized traffic against the model
        do_reset;
        repeat (800) begin
            Flag_IN = ($urandom % 3) == 0;
            Data_IN = $urandom;
            Carry_IN = $urandom % 2;
            Byte_Ready = ($urandom % 4) != 0;
            Clear_Overflow = ($urandom % 16) == 0;
            RST = ($urandom % 200) == 0;
            tick;
        end
        RST = 1'b0;
        Flag_IN = 1'b0;
        Clear_Overflow = 1'b0;
        Byte_Ready = 1'b1;
        repeat (40) tick;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
